// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl: WIDTH x DEPTH register bank behind a select/ack controller.
// One outstanding access at a time; reads/writes complete in a RESP state.
//
// Ports:
//   clk, reset (async, active-low)
//   select/op/addr/din : request (sampled only while ready=1)
//   ack                : response accept (sampled only while valid=1)
//   ready/valid        : controller idle / response available
//   rw/err/dout        : captured op, out-of-range flag, read data
module mem_bank_ctrl #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             op,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic             rw,
  output logic             err,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    READ  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t state;
  state_t state_next;

  logic             req_op;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_din;
  logic             err_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_range;
  logic [WIDTH-1:0] rd_data;

  // Non-power-of-two depths leave addressable holes above DEPTH-1.
  assign in_range = ({1'b0, req_addr} < DEPTH_C);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_addr == AW'(i)) rd_data = mem[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    valid      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (select) state_next = op ? WRITE : READ;
      end
      WRITE: state_next = RESP;
      READ:  state_next = RESP;
      RESP: begin
        valid = 1'b1;
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_op   <= 1'b0;
      req_addr <= '0;
      req_din  <= '0;
      err_q    <= 1'b0;
      dout_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == IDLE && select) begin
        req_op   <= op;
        req_addr <= addr;
        req_din  <= din;
      end
      if (state == WRITE || state == READ) err_q <= ~in_range;
      if (state == READ) dout_q <= in_range ? rd_data : '0;
      if (state == WRITE && in_range) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (req_addr == AW'(i)) mem[i] <= req_din;
        end
      end
    end
  end

  assign rw   = req_op;
  assign err  = err_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl across four parameter builds.
// Stimulus pushes expected responses; a negedge monitor pops and checks.
module tb_mem_bank_ctrl;

  typedef struct packed {
    logic        rw;
    logic        err;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cur = 2'd0;
  logic        sel = 1'b0;
  logic        op_b = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  addr_b = '0;
  logic [31:0] din_b = '0;

  logic [3:0]  rdy, vld, rwv, erv;
  logic [7:0]  dout0, dout1;
  logic        dout2;
  logic [31:0] dout3;

  logic        m_ready, m_valid, m_rw, m_err;
  logic [31:0] m_dout;

  int tests = 0;
  int fails = 0;
  int rcount = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mem_bank_ctrl #(.WIDTH(8), .DEPTH(16)) u0 (
    .clk(clk), .reset(reset), .select(sel && cur == 2'd0), .op(op_b),
    .addr(addr_b[3:0]), .din(din_b[7:0]), .ack(ack),
    .ready(rdy[0]), .valid(vld[0]), .rw(rwv[0]), .err(erv[0]), .dout(dout0)
  );

  mem_bank_ctrl #(.WIDTH(8), .DEPTH(12)) u1 (
    .clk(clk), .reset(reset), .select(sel && cur == 2'd1), .op(op_b),
    .addr(addr_b[3:0]), .din(din_b[7:0]), .ack(ack),
    .ready(rdy[1]), .valid(vld[1]), .rw(rwv[1]), .err(erv[1]), .dout(dout1)
  );

  mem_bank_ctrl #(.WIDTH(1), .DEPTH(2)) u2 (
    .clk(clk), .reset(reset), .select(sel && cur == 2'd2), .op(op_b),
    .addr(addr_b[0:0]), .din(din_b[0:0]), .ack(ack),
    .ready(rdy[2]), .valid(vld[2]), .rw(rwv[2]), .err(erv[2]), .dout(dout2)
  );

  mem_bank_ctrl #(.WIDTH(32), .DEPTH(64)) u3 (
    .clk(clk), .reset(reset), .select(sel && cur == 2'd3), .op(op_b),
    .addr(addr_b[5:0]), .din(din_b), .ack(ack),
    .ready(rdy[3]), .valid(vld[3]), .rw(rwv[3]), .err(erv[3]), .dout(dout3)
  );

  always_comb begin
    m_ready = rdy[cur];
    m_valid = vld[cur];
    m_rw    = rwv[cur];
    m_err   = erv[cur];
    m_dout  = '0;
    case (cur)
      2'd0:    m_dout = {24'b0, dout0};
      2'd1:    m_dout = {24'b0, dout1};
      2'd2:    m_dout = {31'b0, dout2};
      default: m_dout = dout3;
    endcase
  end

  // Monitor: one comparison per response, on the cycle it is acked.
  always @(negedge clk) begin
    if (reset && m_valid && ack) begin
      tests++;
      rcount++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: got rw=%0b err=%0b dout=%0h, required none",
                 m_rw, m_err, m_dout);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (m_rw !== e.rw || m_err !== e.err ||
            (!e.rw && m_dout !== e.dout)) begin
          fails++;
          $display("FAIL resp: got rw=%0b err=%0b dout=%0h, required rw=%0b err=%0b dout=%0h",
                   m_rw, m_err, m_dout, e.rw, e.err, e.dout);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!m_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(m_ready), 64'd1);
  endtask

  task automatic access(input logic o, input logic [7:0] a, input logic [31:0] d,
                        input logic ee, input logic [31:0] ed, input int hold);
    wait_ready();
    q.push_back('{o, ee, ed});
    sel = 1'b1; op_b = o; addr_b = a; din_b = d;
    tick();
    sel = 1'b0; op_b = ~o; addr_b = ~a; din_b = ~d;
    chk("accept", 64'({m_ready, m_valid}), 64'd0);
    tick();
    chk("valid", 64'({m_ready, m_valid}), 64'b01);
    for (int k = 0; k < hold; k++) begin
      sel = k[0]; op_b = 1'b1; addr_b = a; din_b = '0;
      tick();
      chk("hold", 64'({m_ready, m_valid, m_rw, m_err, m_dout}),
          64'({1'b0, 1'b1, o, ee, ed}));
    end
    sel = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("release", 64'({m_ready, m_valid}), 64'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a8;
    int base;
    repeat (2) tick();
    chk("rst_hold", 64'({m_ready, m_valid, m_rw, m_err, m_dout}), 64'({4'b1000, 32'd0}));
    reset = 1'b1;
    tick();

    // Reset mid-write drops the write and clears storage/dout.
    cur = 2'd0;
    access(1'b1, 8'd3, 32'h11, 1'b0, 32'h0, 0);
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h11, 0);
    wait_ready();
    sel = 1'b1; op_b = 1'b1; addr_b = 8'd3; din_b = 32'hA5;
    tick();
    sel = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_ctl", 64'({m_ready, m_valid, m_rw, m_err}), 64'b1000);
    chk("rst_mid_dout", 64'(m_dout), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h00, 0);

    // Write then read.
    access(1'b1, 8'd7, 32'h5A, 1'b0, 32'h0, 0);
    access(1'b0, 8'd7, 32'h0, 1'b0, 32'h5A, 0);

    // Back-to-back with select and ack held high.
    base = rcount;
    wait_ready();
    sel = 1'b1; ack = 1'b1;
    for (int k = 0; k < 32; k++) begin
      a8 = 8'(k >> 1);
      op_b = ~k[0]; addr_b = a8; din_b = 32'(a8 ^ 8'h3C);
      chk("b2b_ready", 64'(m_ready), 64'd1);
      q.push_back('{~k[0], 1'b0, 32'(a8 ^ 8'h3C)});
      tick();
      chk("b2b_busy", 64'(m_ready), 64'd0);
      tick();
      tick();
    end
    sel = 1'b0; ack = 1'b0;
    chk("b2b_count", 64'(rcount - base), 64'd32);

    // Backpressure: response held, select pulses ignored.
    access(1'b0, 8'd2, 32'h0, 1'b0, 32'h3E, 10);
    access(1'b0, 8'd2, 32'h0, 1'b0, 32'h3E, 0);

    // DEPTH=12: out-of-range accesses flag err and touch nothing.
    cur = 2'd1;
    access(1'b1, 8'd11, 32'h3C, 1'b0, 32'h0, 0);
    access(1'b0, 8'd11, 32'h0, 1'b0, 32'h3C, 0);
    access(1'b1, 8'd13, 32'hFF, 1'b1, 32'h0, 0);
    access(1'b0, 8'd13, 32'h0, 1'b1, 32'h00, 0);
    access(1'b0, 8'd5, 32'h0, 1'b0, 32'h00, 0);
    access(1'b0, 8'd1, 32'h0, 1'b0, 32'h00, 0);
    access(1'b0, 8'd11, 32'h0, 1'b0, 32'h3C, 0);

    // WIDTH=1 / DEPTH=2.
    cur = 2'd2;
    access(1'b1, 8'd1, 32'h1, 1'b0, 32'h0, 0);
    access(1'b0, 8'd1, 32'h0, 1'b0, 32'h1, 0);
    access(1'b1, 8'd0, 32'h1, 1'b0, 32'h0, 0);
    access(1'b1, 8'd1, 32'h0, 1'b0, 32'h0, 0);
    access(1'b0, 8'd0, 32'h0, 1'b0, 32'h1, 0);
    access(1'b0, 8'd1, 32'h0, 1'b0, 32'h0, 0);

    // WIDTH=32 / DEPTH=64: all-ones and walking-one.
    cur = 2'd3;
    access(1'b1, 8'd63, 32'hFFFF_FFFF, 1'b0, 32'h0, 0);
    access(1'b0, 8'd63, 32'h0, 1'b0, 32'hFFFF_FFFF, 0);
    for (int b = 0; b < 32; b++)
      access(1'b1, 8'(b), 32'd1 << b, 1'b0, 32'h0, 0);
    for (int b = 0; b < 32; b++)
      access(1'b0, 8'(b), 32'h0, 1'b0, 32'd1 << b, 0);
    access(1'b0, 8'd40, 32'h0, 1'b0, 32'h0, 0);

    tick();
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
